uart8: RTL and testbench
========================

# uart8

Full-duplex 8N1 UART for the board-level serial link. It holds a 16x-oversampling receiver and a 1x-baud transmitter, both driven from one system clock through integer baud dividers. It sits between the pad-level serial lines and byte-wide user logic.

## Interface
- CLOCK_RATE, 12000000: system clock frequency, Hz.
- BAUD_RATE, 9600: line rate, bits/s.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- rxEn  in  1  receiver enable; low forces the receiver to idle.
- rxIn  in  1  serial input, idle high.
- rxBusy  out  1  high while a frame is being received.
- rxDone  out  1  one-clk pulse when a frame completes with a valid stop bit.
- rxErr  out  1  framing error flag, held high.
- rxOut  out  8  last received byte.
- txEn  in  1  transmitter enable.
- txStart  in  1  request to send; sampled when txEn=1 and txBusy=0.
- txIn  in  8  byte to send, latched on an accepted txStart.
- txOut  out  1  serial output, idle high.
- txBusy  out  1  high from an accepted txStart until the end of the stop bit.
- txDone  out  1  one-clk pulse at the end of the stop bit.

## Operation
- Reset values: rxBusy=0, rxDone=0, rxErr=0, rxOut=8'h00, txOut=1, txBusy=0, txDone=0. Both FSMs go to IDLE.
- Baud ticks:
  - Rx tick divider = CLOCK_RATE/(BAUD_RATE*16), integer and truncated: 78 at default.
  - Tx tick divider = CLOCK_RATE/BAUD_RATE: 1250 at default.
  - Each divider is a counter that wraps to 0 and emits a one-clk tick.
- rxIn passes through a 2-flop synchronizer before any use.
- Rx FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE: on a synchronized falling edge with rxEn=1, reset the rx tick counter and sample counter, set rxBusy=1, clear rxErr, go to START.
  - START: at sample 8 (mid-bit), if the line is high it is a glitch: go to IDLE, set rxBusy=0, leave rxErr=0, no rxDone. If the line is low, realign so later samples fall mid-bit, then go to DATA.
  - DATA: every 16 rx ticks, shift in one bit LSB first. After 8 bits, go to STOP.
  - STOP: sample mid-bit. If high, load rxOut and pulse rxDone. If low, set rxErr=1 and leave rxOut unchanged. In both cases set rxBusy=0 and go to IDLE.
  - rxEn low in any state aborts to IDLE with rxBusy=0. rxOut and rxErr are kept.
- Tx FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - An accepted txStart latches txIn and restarts the tx divider. Each state lasts one tx tick period: txOut=0 for START, data LSB first for DATA, 1 for STOP.
  - txDone pulses and txBusy falls on the last clk of STOP.
  - txStart while busy is ignored.
  - txEn low aborts to IDLE with txOut=1.

## Timing
- Rx start qualification: 8 rx ticks (about 624 clk) after the synchronized falling edge.
- rxDone asserts in the clk after the stop-bit mid-sample, about 9.5 bit periods after the start edge plus 2 clk of synchronizer.
- Receiver tolerates ±3% baud mismatch.
- Tx frame is exactly 10x1250 clk at default. txOut changes on the clk after the tx tick.
- An rxEn rising edge while rxIn is already low does not start a frame. A falling edge is required.

## Configuration
- UART8_MAJORITY_VOTE_EN defined: each rx bit (start, data, stop) is the 2-of-3 majority of samples 7, 8 and 9.
- Undefined: each rx bit is the single sample 8.
- The glitch-reject rule applies to the voted value when defined.

## Test plan
- Reset low mid-frame: all outputs return to their reset values within 1 clk, and txOut=1.
- rxIn low for 300 clk then high, rxEn=1: rxBusy pulses, then returns to 0 with no rxDone and rxErr=0.
- Receive 8'b00110101 at 9600 baud: rxDone pulses once, rxOut=8'h35, rxErr=0.
- Same byte sent with a 3% longer bit period (1288 clk): rxOut=8'h35.
- Frame with stop bit 0: rxErr=1, no rxDone, rxOut keeps its prior value. The next good frame clears rxErr at its start edge.
- txStart with txIn=8'hA5:
  - txOut sequence: 0,1,0,1,0,0,1,0,1,1, each bit 1250 clk.
  - txBusy high for 12500 clk, single txDone pulse.
  - A second txStart during the frame is ignored.

Source files
------------

// File: rtl/uart8.sv
// uart8 - full-duplex 8N1 UART.
//
// A 16x-oversampling receiver and a 1x-baud transmitter share one system
// clock. Each side derives its tick from an integer divider of CLOCK_RATE.
//
// Optional build macro:
//   UART8_MAJORITY_VOTE_EN - when defined, each received bit (start, data
//   and stop) is the 2-of-3 majority of oversamples 7, 8 and 9. When it is
//   undefined, each bit is the single oversample 8.
//
// Ports:
//   clk      in   system clock, rising edge
//   reset    in   asynchronous active-low reset
//   rxEn     in   receiver enable; low forces the receiver back to idle
//   rxIn     in   serial input, idle high
//   rxBusy   out  high while a frame is being received
//   rxDone   out  one-clk pulse when a frame ends with a valid stop bit
//   rxErr    out  framing error flag, held until the next start edge
//   rxOut    out  last good received byte
//   txEn     in   transmitter enable; low aborts to idle with txOut high
//   txStart  in   send request, accepted when txEn=1 and txBusy=0
//   txIn     in   byte to send, latched on an accepted txStart
//   txOut    out  serial output, idle high
//   txBusy   out  high from an accepted txStart to the end of the stop bit
//   txDone   out  one-clk pulse on the last clk of the stop bit
`timescale 1ns/1ps
module uart8 #(
  parameter int CLOCK_RATE = 12000000,
  parameter int BAUD_RATE  = 9600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxEn,
  input  logic       rxIn,
  output logic       rxBusy,
  output logic       rxDone,
  output logic       rxErr,
  output logic [7:0] rxOut,
  input  logic       txEn,
  input  logic       txStart,
  input  logic [7:0] txIn,
  output logic       txOut,
  output logic       txBusy,
  output logic       txDone
);

  localparam int RX_DIV   = CLOCK_RATE / (BAUD_RATE * 16);
  localparam int TX_DIV   = CLOCK_RATE / BAUD_RATE;
  localparam int RX_DIV_W = (RX_DIV > 1) ? $clog2(RX_DIV) : 1;
  localparam int TX_DIV_W = (TX_DIV > 1) ? $clog2(TX_DIV) : 1;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rxState_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} txState_t;

  // ---------------------------------------------------------------- receiver
  logic                rxSync_p0, rxSync_p1, rxPrev;
  logic                rxS, rxFall, rxTick, rxDecide, rxBitVal, rxDivClr;
  logic [RX_DIV_W-1:0] rxDivCnt;
  logic [3:0]          rxSampleCnt, rxSampleNext;
  logic [4:0]          sampleIdx;
  logic [2:0]          rxBitCnt, rxBitNext;
  logic [7:0]          rxShift, rxShiftNext, rxOutNext;
  logic                rxErrNext, rxDoneNext;
  rxState_t            rxState, rxStateNext;

  assign rxS       = rxSync_p1;
  assign rxFall    = rxPrev & ~rxS;
  assign rxTick    = (rxDivCnt == RX_DIV_W'(RX_DIV - 1));
  // Oversample number (1..16) that the current tick completes within the bit.
  assign sampleIdx = {1'b0, rxSampleCnt} + 5'd1;
  assign rxBusy    = (rxState != RX_IDLE);

`ifdef UART8_MAJORITY_VOTE_EN
  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  logic rxV7, rxV8;

  always_ff @(posedge clk) begin
    if (rxTick && sampleIdx == 5'd7) rxV7 <= rxS;
    if (rxTick && sampleIdx == 5'd8) rxV8 <= rxS;
  end

  assign rxDecide = rxTick && (sampleIdx == 5'd9);
  assign rxBitVal = majority3(rxV7, rxV8, rxS);
`else
  assign rxDecide = rxTick && (sampleIdx == 5'd8);
  assign rxBitVal = rxS;
`endif

  always_comb begin
    rxStateNext  = rxState;
    rxSampleNext = rxSampleCnt;
    rxBitNext    = rxBitCnt;
    rxShiftNext  = rxShift;
    rxOutNext    = rxOut;
    rxErrNext    = rxErr;
    rxDoneNext   = 1'b0;
    rxDivClr     = 1'b0;
    // The sample counter wraps 15 -> 0 at each bit boundary; the divider
    // was cleared on the start edge, so boundaries stay bit-aligned and
    // sample 8 of every bit lands mid-bit.
    if (rxState != RX_IDLE && rxTick) rxSampleNext = rxSampleCnt + 4'd1;
    if (!rxEn) begin
      rxStateNext = RX_IDLE;
    end else begin
      unique case (rxState)
        RX_IDLE: begin
          if (rxFall) begin
            rxDivClr     = 1'b1;
            rxSampleNext = '0;
            rxErrNext    = 1'b0;
            rxStateNext  = RX_START;
          end
        end
        RX_START: begin
          if (rxDecide && rxBitVal) rxStateNext = RX_IDLE;  // glitch
          else if (rxTick && sampleIdx == 5'd16) begin
            rxBitNext   = '0;
            rxStateNext = RX_DATA;
          end
        end
        RX_DATA: begin
          if (rxDecide) rxShiftNext = {rxBitVal, rxShift[7:1]};
          if (rxTick && sampleIdx == 5'd16) begin
            if (rxBitCnt == 3'd7) rxStateNext = RX_STOP;
            else rxBitNext = rxBitCnt + 3'd1;
          end
        end
        RX_STOP: begin
          if (rxDecide) begin
            if (rxBitVal) begin
              rxOutNext  = rxShift;
              rxDoneNext = 1'b1;
            end else begin
              rxErrNext = 1'b1;
            end
            rxStateNext = RX_IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rxSync_p0   <= 1'b1;
      rxSync_p1   <= 1'b1;
      rxPrev      <= 1'b1;
      rxState     <= RX_IDLE;
      rxDivCnt    <= '0;
      rxSampleCnt <= '0;
      rxBitCnt    <= '0;
      rxOut       <= '0;
      rxErr       <= 1'b0;
      rxDone      <= 1'b0;
    end else begin
      rxSync_p0   <= rxIn;
      rxSync_p1   <= rxSync_p0;
      rxPrev      <= rxSync_p1;
      rxState     <= rxStateNext;
      rxDivCnt    <= (rxDivClr || rxTick) ? '0 : rxDivCnt + RX_DIV_W'(1);
      rxSampleCnt <= rxSampleNext;
      rxBitCnt    <= rxBitNext;
      rxOut       <= rxOutNext;
      rxErr       <= rxErrNext;
      rxDone      <= rxDoneNext;
    end
  end

  always_ff @(posedge clk) rxShift <= rxShiftNext;

  // ------------------------------------------------------------- transmitter
  logic                txTick, txDivClr, txOutNext;
  logic [TX_DIV_W-1:0] txDivCnt;
  logic [2:0]          txBitCnt, txBitNext;
  logic [7:0]          txShift, txShiftNext;
  txState_t            txState, txStateNext;

  assign txTick = (txDivCnt == TX_DIV_W'(TX_DIV - 1));
  assign txBusy = (txState != TX_IDLE);
  assign txDone = txEn && (txState == TX_STOP) && txTick;

  always_comb begin
    txStateNext = txState;
    txShiftNext = txShift;
    txBitNext   = txBitCnt;
    txOutNext   = txOut;
    txDivClr    = 1'b0;
    if (!txEn) begin
      txStateNext = TX_IDLE;
      txOutNext   = 1'b1;
    end else begin
      unique case (txState)
        TX_IDLE: begin
          txOutNext = 1'b1;
          if (txStart) begin
            txShiftNext = txIn;
            txDivClr    = 1'b1;
            txOutNext   = 1'b0;
            txStateNext = TX_START;
          end
        end
        TX_START: begin
          if (txTick) begin
            txOutNext   = txShift[0];
            txShiftNext = txShift >> 1;
            txBitNext   = '0;
            txStateNext = TX_DATA;
          end
        end
        TX_DATA: begin
          if (txTick) begin
            if (txBitCnt == 3'd7) begin
              txOutNext   = 1'b1;
              txStateNext = TX_STOP;
            end else begin
              txOutNext   = txShift[0];
              txShiftNext = txShift >> 1;
              txBitNext   = txBitCnt + 3'd1;
            end
          end
        end
        TX_STOP: begin
          if (txTick) txStateNext = TX_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      txState  <= TX_IDLE;
      txDivCnt <= '0;
      txBitCnt <= '0;
      txOut    <= 1'b1;
    end else begin
      txState  <= txStateNext;
      txDivCnt <= (txDivClr || txTick) ? '0 : txDivCnt + TX_DIV_W'(1);
      txBitCnt <= txBitNext;
      txOut    <= txOutNext;
    end
  end

  always_ff @(posedge clk) txShift <= txShiftNext;

endmodule

// File: tb/tb_uart8.sv
`timescale 1ns/1ps
module tb_uart8;

  localparam int BIT      = 12000000 / 9600;   // 1250 clk per bit
  localparam int TX_FRAME = 10 * BIT;
  localparam int RX_TAIL  = 100;

  logic       clk = 1'b0;
  logic       reset, rxEn, rxIn, txEn, txStart;
  logic [7:0] txIn;
  logic       rxBusy, rxDone, rxErr, txOut, txBusy, txDone;
  logic [7:0] rxOut;

  int         testsRun = 0;
  int         failCnt  = 0;
  int         rxDoneCnt = 0;
  logic [7:0] expOut;

  uart8 dut (
    .clk    (clk),
    .reset  (reset),
    .rxEn   (rxEn),
    .rxIn   (rxIn),
    .rxBusy (rxBusy),
    .rxDone (rxDone),
    .rxErr  (rxErr),
    .rxOut  (rxOut),
    .txEn   (txEn),
    .txStart(txStart),
    .txIn   (txIn),
    .txOut  (txOut),
    .txBusy (txBusy),
    .txDone (txDone)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (rxDone === 1'b1) rxDoneCnt = rxDoneCnt + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp)
    else begin
      failCnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one 8N1 frame on rxIn with the given bit period, then compare the
  // receiver against the frame's meaning: a good stop bit delivers the byte,
  // a bad one flags an error and keeps the previous byte.
  task automatic sendRx(input logic [7:0] data, input logic stopBit, input int bitLen);
    logic [9:0] frame;
    int         done0;
    frame = {stopBit, data, 1'b0};
    done0 = rxDoneCnt;
    for (int k = 0; k < 10; k++) begin
      rxIn = frame[k];
      for (int c = 0; c < bitLen; c++) begin
        @(negedge clk);
        if (k == 0 && c == 10) begin
          check("rxBusy at start", 32'(rxBusy), 32'(1));
          check("rxErr cleared at start", 32'(rxErr), 32'(0));
        end
      end
    end
    rxIn = 1'b1;
    repeat (RX_TAIL) @(negedge clk);
    if (stopBit) expOut = data;
    check("rxDone pulses", 32'(rxDoneCnt - done0), stopBit ? 32'(1) : 32'(0));
    check("rxOut", 32'(rxOut), 32'(expOut));
    check("rxErr", 32'(rxErr), 32'(!stopBit));
    check("rxBusy after frame", 32'(rxBusy), 32'(0));
  endtask

  // Request one transmission and compare txOut against the 10-bit frame at
  // the first and last clk of every bit; a second request is made at dupAt.
  task automatic sendTx(input logic [7:0] data, input int dupAt);
    logic [9:0] frame;
    int         busyCnt, doneCnt, doneAt;
    frame   = {1'b1, data, 1'b0};
    busyCnt = 0;
    doneCnt = 0;
    doneAt  = -1;
    txIn    = data;
    txStart = 1'b1;
    @(negedge clk);
    for (int j = 0; j <= TX_FRAME; j++) begin
      if (txBusy) busyCnt++;
      if (txDone) begin
        doneCnt++;
        doneAt = j;
      end
      if (j < TX_FRAME && (j % BIT == 0 || j % BIT == BIT - 1))
        check($sformatf("txOut bit%0d clk%0d", j / BIT, j % BIT), 32'(txOut), 32'(frame[j / BIT]));
      txStart = (j == dupAt);
      if (j == dupAt) txIn = ~data;
      @(negedge clk);
    end
    txStart = 1'b0;
    check("txBusy clk count", 32'(busyCnt), 32'(TX_FRAME));
    check("txDone count", 32'(doneCnt), 32'(1));
    check("txDone position", 32'(doneAt), 32'(TX_FRAME - 1));
    check("txOut idle", 32'(txOut), 32'(1));
    check("txBusy idle", 32'(txBusy), 32'(0));
  endtask

  initial begin
    logic [7:0] d;
    int         done0;
    reset   = 1'b0;
    rxEn    = 1'b1;
    rxIn    = 1'b1;
    txEn    = 1'b1;
    txStart = 1'b0;
    txIn    = 8'h00;
    expOut  = 8'h00;

    // Reset state
    repeat (5) @(negedge clk);
    check("reset rxBusy", 32'(rxBusy), 32'(0));
    check("reset rxDone", 32'(rxDone), 32'(0));
    check("reset rxErr", 32'(rxErr), 32'(0));
    check("reset rxOut", 32'(rxOut), 32'(8'h00));
    check("reset txOut", 32'(txOut), 32'(1));
    check("reset txBusy", 32'(txBusy), 32'(0));
    check("reset txDone", 32'(txDone), 32'(0));
    reset = 1'b1;
    repeat (5) @(negedge clk);

    // Short low glitch: receiver starts, then rejects at mid-bit
    done0 = rxDoneCnt;
    rxIn = 1'b0;
    repeat (10) @(negedge clk);
    check("glitch rxBusy rises", 32'(rxBusy), 32'(1));
    repeat (290) @(negedge clk);
    rxIn = 1'b1;
    repeat (700) @(negedge clk);
    check("glitch rxBusy falls", 32'(rxBusy), 32'(0));
    check("glitch no rxDone", 32'(rxDoneCnt - done0), 32'(0));
    check("glitch rxErr", 32'(rxErr), 32'(0));

    // Enabling the receiver while the line is already low starts nothing
    rxEn = 1'b0;
    rxIn = 1'b0;
    repeat (20) @(negedge clk);
    rxEn = 1'b1;
    repeat (700) @(negedge clk);
    check("rxEn rise on low line", 32'(rxBusy), 32'(0));
    rxIn = 1'b1;
    repeat (50) @(negedge clk);

    // Nominal receive of 0x35 alongside transmit of 0xA5
    fork
      sendRx(8'h35, 1'b1, BIT);
      sendTx(8'hA5, 5000);
    join

    // 3% slow sender alongside a random transmit byte
    d = 8'($urandom);
    fork
      sendRx(8'h35, 1'b1, 1288);
      sendTx(d, int'($urandom_range(100, TX_FRAME - 100)));
    join

    // Bad stop bit, then a good random frame that clears the error
    d = 8'($urandom);
    if (d == expOut) d = ~d;
    sendRx(d, 1'b0, BIT);
    d = 8'($urandom_range(1, 255));
    sendRx(d, 1'b1, BIT);

    // Reset in the middle of an rx frame and a tx frame
    txIn    = {7'($urandom), 1'b0};
    txStart = 1'b1;
    rxIn    = 1'b0;
    @(negedge clk);
    txStart = 1'b0;
    repeat (2000) @(negedge clk);
    check("midframe rxBusy before reset", 32'(rxBusy), 32'(1));
    check("midframe txBusy before reset", 32'(txBusy), 32'(1));
    #2 reset = 1'b0;
    #1;
    check("midframe reset rxBusy", 32'(rxBusy), 32'(0));
    check("midframe reset rxDone", 32'(rxDone), 32'(0));
    check("midframe reset rxErr", 32'(rxErr), 32'(0));
    check("midframe reset rxOut", 32'(rxOut), 32'(8'h00));
    check("midframe reset txOut", 32'(txOut), 32'(1));
    check("midframe reset txBusy", 32'(txBusy), 32'(0));
    check("midframe reset txDone", 32'(txDone), 32'(0));
    @(negedge clk);
    rxIn  = 1'b1;
    reset = 1'b1;
    repeat (20) @(negedge clk);
    check("post reset rxBusy", 32'(rxBusy), 32'(0));
    check("post reset txOut", 32'(txOut), 32'(1));

    $display("[TB] %0d tests run, %0d failed", testsRun, failCnt);
    $finish;
  end

endmodule
